// File: rtl/scrambler_tx_32b_if.sv
// Block-side handshake and gearbox-side half-block bus of the 64b/66b TX scrambler.
// The encoder/bench is the master, the scrambler is the slave.
interface scrambler_tx_32b_if;
    logic [63:0] blk_data;
    logic [1:0]  blk_hdr;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] tx_data;
    logic [1:0]  tx_hdr;
    logic        tx_en;
    logic        tx_even;
    logic        underflow;

    modport master (
        output blk_data, blk_hdr, blk_valid,
        input  blk_ready, tx_data, tx_hdr, tx_en, tx_even, underflow
    );

    modport slave (
        input  blk_data, blk_hdr, blk_valid,
        output blk_ready, tx_data, tx_hdr, tx_en, tx_even, underflow
    );
endinterface

// File: rtl/scrambler_tx_32b.sv
// 10GBASE-R TX scrambler (x^58 + x^39 + 1) emitting 66-bit blocks as 32-bit halves,
// paced for a 32-bit gearbox: 32 enabled slots then 1 idle slot per period.
module scrambler_tx_32b #(
    parameter logic [57:0] SCR_INIT   = 58'h3FF_FFFF_FFFF_FFFF,
    parameter bit          SCR_BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    scrambler_tx_32b_if.slave  bus
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_RUN    = 1'b1;
    localparam logic [5:0]  LAST_SLOT = 6'd32;
    localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001E;
    localparam logic [1:0]  IDLE_HDR  = 2'b01;

    logic [0:0]  state_q, state_d;
    logic [5:0]  slot_q, slot_d;
    logic [57:0] scr_q, scr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [1:0]  tx_hdr_q, tx_hdr_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_even_q, tx_even_d;
    logic        underflow_q, underflow_d;

    logic        rdy;
    logic        emit_hi;
    logic [31:0] word_in;
    logic [31:0] word_out;
    logic [57:0] scr_nxt;
    logic        fb;

    // Ready precedes every even slot 0..30: IDLE/slot 32 going to slot 0, or odd slots 1..29.
    always_comb begin
        rdy = 1'b0;
        if (state_q == ST_IDLE)
            rdy = en;
        else if (slot_q == LAST_SLOT)
            rdy = en;
        else
            rdy = slot_q[0] && (slot_q <= 6'd29);
    end

    assign bus.blk_ready = rdy & rst_n;
    assign emit_hi = (state_q == ST_RUN) && !slot_q[0] && (slot_q <= 6'd30);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (state_q == ST_IDLE) begin
            if (en) begin
                state_d = ST_RUN;
                slot_d  = 6'd0;
            end
        end else if (slot_q == LAST_SLOT) begin
            slot_d = 6'd0;
            if (!en)
                state_d = ST_IDLE;
        end else begin
            slot_d = slot_q + 6'd1;
        end
    end

    always_comb begin
        word_in = hi_q;
        if (rdy)
            word_in = bus.blk_valid ? bus.blk_data[31:0] : IDLE_BLK[31:0];
    end

    // Unrolled self-synchronous scrambler; the state always shifts in the transmitted bit.
    always_comb begin
        scr_nxt  = scr_q;
        word_out = '0;
        fb       = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fb          = word_in[i] ^ scr_nxt[38] ^ scr_nxt[57];
            word_out[i] = SCR_BYPASS ? word_in[i] : fb;
            scr_nxt     = {scr_nxt[56:0], word_out[i]};
        end
    end

    always_comb begin
        tx_data_d   = '0;
        tx_hdr_d    = tx_hdr_q;
        tx_en_d     = 1'b0;
        tx_even_d   = 1'b0;
        underflow_d = 1'b0;
        hi_d        = hi_q;
        scr_d       = scr_q;
        if (rdy) begin
            tx_data_d   = word_out;
            tx_en_d     = 1'b1;
            tx_even_d   = 1'b1;
            tx_hdr_d    = bus.blk_valid ? bus.blk_hdr : IDLE_HDR;
            underflow_d = !bus.blk_valid;
            hi_d        = bus.blk_valid ? bus.blk_data[63:32] : IDLE_BLK[63:32];
            scr_d       = scr_nxt;
        end else if (emit_hi) begin
            tx_data_d = word_out;
            tx_en_d   = 1'b1;
            scr_d     = scr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            scr_q       <= SCR_INIT;
            hi_q        <= '0;
            tx_data_q   <= '0;
            tx_hdr_q    <= '0;
            tx_en_q     <= 1'b0;
            tx_even_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            scr_q       <= scr_d;
            hi_q        <= hi_d;
            tx_data_q   <= tx_data_d;
            tx_hdr_q    <= tx_hdr_d;
            tx_en_q     <= tx_en_d;
            tx_even_q   <= tx_even_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_hdr    = tx_hdr_q;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_even   = tx_even_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_scrambler_tx_32b.sv
// Directed bench for scrambler_tx_32b: cadence, passthrough, underflow, en control,
// mid-period reset, plus a descrambler scoreboard on the scrambling instance.
module tb_scrambler_tx_32b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [63:0] blk_data;
    logic [1:0]  blk_hdr;
    logic        blk_valid;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scrambler_tx_32b_if ifb ();
    scrambler_tx_32b_if ifs ();

    assign ifb.blk_data  = blk_data;
    assign ifb.blk_hdr   = blk_hdr;
    assign ifb.blk_valid = blk_valid;
    assign ifs.blk_data  = blk_data;
    assign ifs.blk_hdr   = blk_hdr;
    assign ifs.blk_valid = blk_valid;

    scrambler_tx_32b #(.SCR_BYPASS(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .en(en), .bus(ifb));
    scrambler_tx_32b #(.SCR_BYPASS(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .en(en), .bus(ifs));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  hdr;
        logic        lo;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [57:0] dsc = '0;
    logic [31:0] rec;
    int          nword = 0;

    // Descrambler scoreboard on the scrambling instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            nword = 0;
        end else begin
            if (ifs.tx_en) begin
                for (int i = 0; i < 32; i++) begin
                    rec[i] = ifs.tx_data[i] ^ dsc[38] ^ dsc[57];
                    dsc    = {dsc[56:0], ifs.tx_data[i]};
                end
                nword++;
                chk("sb_q_nonempty", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sb_even", 64'(ifs.tx_even), 64'(e.lo));
                    if (nword > 2) chk("sb_payload", 64'(rec), 64'(e.data));
                    if (e.lo) chk("sb_hdr", 64'(ifs.tx_hdr), 64'(e.hdr));
                end
            end
            if (ifs.blk_ready) begin
                if (blk_valid) begin
                    sbq.push_back('{data: blk_data[31:0],  hdr: blk_hdr, lo: 1'b1});
                    sbq.push_back('{data: blk_data[63:32], hdr: blk_hdr, lo: 1'b0});
                end else begin
                    sbq.push_back('{data: 32'h0000_001E, hdr: 2'b01, lo: 1'b1});
                    sbq.push_back('{data: 32'h0,         hdr: 2'b01, lo: 1'b0});
                end
            end
        end
    end

    int          acc;
    int          und;
    int          j;
    logic        x_en;
    logic        x_even;
    logic [31:0] x_data;

    initial begin
        rst_n = 1'b0; en = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_hdr = '0;

        // Reset state, including ready held low despite en=1
        @(negedge clk);
        chk("rst_tx_data",   64'(ifb.tx_data),   64'd0);
        chk("rst_tx_hdr",    64'(ifb.tx_hdr),    64'd0);
        chk("rst_tx_en",     64'(ifb.tx_en),     64'd0);
        chk("rst_tx_even",   64'(ifb.tx_even),   64'd0);
        chk("rst_underflow", 64'(ifb.underflow), 64'd0);
        chk("rst_ready",     64'(ifb.blk_ready), 64'd0);
        en = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Cadence + passthrough: 3 periods, then en drops at slot 32
        acc = 0;
        for (int c = 0; c <= 98; c++) begin
            en = (c != 98); blk_valid = 1'b1;
            blk_data = 64'h0123_4567_89AB_CDEF; blk_hdr = 2'b10;
            @(negedge clk);
            if (c == 0) begin
                chk("cad_rdy_idle", 64'(ifb.blk_ready), 64'd1);
                chk("cad_en_idle",  64'(ifb.tx_en),     64'd0);
            end else begin
                j      = (c - 1) % 33;
                x_en   = (j < 32);
                x_even = x_en && (j % 2 == 0);
                x_data = !x_en ? 32'h0 : (x_even ? 32'h89AB_CDEF : 32'h0123_4567);
                chk("cad_tx_en",     64'(ifb.tx_en),     64'(x_en));
                chk("cad_tx_even",   64'(ifb.tx_even),   64'(x_even));
                chk("cad_underflow", 64'(ifb.underflow), 64'd0);
                chk("pass_data",     64'(ifb.tx_data),   64'(x_data));
                if (x_even) chk("pass_hdr", 64'(ifb.tx_hdr), 64'd2);
            end
            if (c == 98) chk("cad_rdy_off", 64'(ifb.blk_ready), 64'd0);
            if (blk_valid && ifb.blk_ready) acc++;
            cyc();
        end
        chk("cad_blocks", 64'(acc), 64'd48);

        // Underflow at slots 6-7, en dropped at slot 10
        und = 0;
        for (int c = 0; c <= 40; c++) begin
            en = (c <= 10); blk_valid = (c != 6);
            blk_data = {32'hB000_0000 + 32'(c), 32'hA000_0000 + 32'(c)}; blk_hdr = 2'b10;
            @(negedge clk);
            if (ifb.underflow) und++;
            case (c)
                0: chk("und_rdy_idle", 64'(ifb.blk_ready), 64'd1);
                7: begin
                    chk("und_lo_data", 64'(ifb.tx_data),   64'h1E);
                    chk("und_lo_hdr",  64'(ifb.tx_hdr),    64'd1);
                    chk("und_lo_even", 64'(ifb.tx_even),   64'd1);
                    chk("und_pulse",   64'(ifb.underflow), 64'd1);
                end
                8: begin
                    chk("und_hi_data", 64'(ifb.tx_data), 64'd0);
                    chk("und_hi_even", 64'(ifb.tx_even), 64'd0);
                    chk("und_hi_en",   64'(ifb.tx_en),   64'd1);
                end
                9: begin
                    chk("und_next_data", 64'(ifb.tx_data), 64'hA000_0008);
                    chk("und_next_hdr",  64'(ifb.tx_hdr),  64'd2);
                    chk("und_next_even", 64'(ifb.tx_even), 64'd1);
                end
                32: chk("en_slot31", 64'(ifb.tx_en), 64'd1);
                33: begin
                    chk("en_slot32_en",   64'(ifb.tx_en),   64'd0);
                    chk("en_slot32_data", 64'(ifb.tx_data), 64'd0);
                end
                default: if (c >= 34) begin
                    chk("en_idle_tx_en", 64'(ifb.tx_en),     64'd0);
                    chk("en_idle_ready", 64'(ifb.blk_ready), 64'd0);
                end
            endcase
            cyc();
        end
        chk("und_count", 64'(und), 64'd1);

        // Re-enable, random traffic for 10 periods, reset at slot 17
        for (int c = 0; c <= 348; c++) begin
            en = 1'b1; blk_valid = ($urandom_range(7) != 0);
            blk_data = {$urandom, $urandom}; blk_hdr = ($urandom_range(1) != 0) ? 2'b10 : 2'b01;
            if (c == 348) begin
                #1 rst_n = 1'b0;
                #1;
                chk("mid_rst_data_s", 64'(ifs.tx_data),   64'd0);
                chk("mid_rst_data_b", 64'(ifb.tx_data),   64'd0);
                chk("mid_rst_hdr",    64'(ifs.tx_hdr),    64'd0);
                chk("mid_rst_en",     64'(ifs.tx_en),     64'd0);
                chk("mid_rst_even",   64'(ifs.tx_even),   64'd0);
                chk("mid_rst_und",    64'(ifs.underflow), 64'd0);
                chk("mid_rst_ready",  64'(ifs.blk_ready), 64'd0);
            end else begin
                @(negedge clk);
                if (c == 0) chk("reen_ready", 64'(ifb.blk_ready), 64'd1);
                if (c == 1) begin
                    chk("reen_slot0_en",   64'(ifb.tx_en),   64'd1);
                    chk("reen_slot0_even", 64'(ifb.tx_even), 64'd1);
                end
                cyc();
            end
        end

        // Restart after reset: scrambler reloaded to all-ones
        blk_data = '0; blk_hdr = 2'b10; blk_valid = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("rst_hold_ready", 64'(ifs.blk_ready), 64'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(ifs.blk_ready), 64'd1);
        chk("rel_tx_en", 64'(ifs.tx_en),     64'd0);
        cyc();
        @(negedge clk);
        chk("rel_s0_en",     64'(ifs.tx_en),   64'd1);
        chk("rel_s0_even",   64'(ifs.tx_even), 64'd1);
        chk("rel_s0_hdr",    64'(ifs.tx_hdr),  64'd2);
        chk("rel_s0_scr",    64'(ifs.tx_data), 64'd0);
        chk("rel_s0_bypass", 64'(ifb.tx_data), 64'd0);
        cyc();
        @(negedge clk);
        chk("rel_s1_scr",  64'(ifs.tx_data), 64'h03FF_FF80);
        chk("rel_s1_even", 64'(ifs.tx_even), 64'd0);
        cyc();
        @(negedge clk);
        chk("rel_s2_even", 64'(ifs.tx_even), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
